pwm_compare_ramp: RTL
=====================

// Module: pwm_compare_ramp
// PURPOSE
//  Upstream stage of PWMGenTop: produces the Compare word fed to the carrier comparators.
//  - Accepts a target duty (compare) value over a valid/ready handshake.
//  - Clamps it to PWMMaxCount and slews Compare toward it by at most RampStep per carrier period.
//  - Updates only on the carrier sync pulse (PeriodSync), so duty never changes mid-period.
// PARAMETERS
//  BIT_WIDTH   16  width of Compare, PWMMaxCount, TargetCompare, RampStep (matches PWMGenTop)
// PORTS
//  MClk            in   1          system clock; all logic on rising edge
//  Rst             in   1          asynchronous, active-high reset
//  Enable          in   1          1 = run; 0 = drive Compare to 0 and return to IDLE
//  PeriodSync      in   1          one-cycle pulse from PWMGenTop at carrier valley (period start)
//  PWMMaxCount     in   BIT_WIDTH  carrier peak; upper clamp for Compare
//  RampStep        in   BIT_WIDTH  max |delta Compare| per period; 0 = jump in a single period
//  TargetCompare   in   BIT_WIDTH  requested compare value
//  TargetValid     in   1          TargetCompare valid
//  TargetReady     out  1          block can accept a target
//  Compare         out  BIT_WIDTH  registered compare value to PWMGenTop
//  CompareUpdated  out  1          one-cycle pulse when Compare changed this cycle
//  AtTarget        out  1          level: Compare == clamped target and state SETTLED
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - Compare=0, CompareUpdated=0, AtTarget=0, TargetReady=0, state=IDLE, target register=0.
//  FSM states: IDLE, SETTLED, RAMPING.
//  - IDLE: Compare held at 0. TargetReady=Enable.
//    - Accept with Enable=1 -> RAMPING.
//  - SETTLED: TargetReady=1. AtTarget=1.
//    - Accept with value != Compare -> RAMPING.
//    - Accept with value == Compare -> stay in SETTLED.
//  - RAMPING: TargetReady=0 (no target overwrite mid-ramp).
//    - On each PeriodSync: diff = target - Compare, computed BIT_WIDTH+1 bits signed.
//      Compare += sign(diff) * min(|diff|, RampStep); RampStep==0 treated as unlimited.
//    - When the update makes Compare == target -> SETTLED in the same cycle.
//  Accept/target rules:
//  - Accept = TargetValid & TargetReady.
//    - Target register <= min(TargetCompare, PWMMaxCount), sampled at accept.
//  - Latency: accept at cycle N; the first Compare change occurs on the first PeriodSync at cycle >= N+1.
//    - A PeriodSync coincident with the accept does not move Compare.
//  - CompareUpdated pulses exactly in the cycle after the PeriodSync edge that changed Compare.
//    - Never pulses on a no-change PeriodSync.
//  - Compare changes only on PeriodSync, the Enable-low path, and reset.
//  Boundary conditions:
//  - PWMMaxCount lowered below Compare or target:
//    - At the next PeriodSync, target <= PWMMaxCount.
//    - Compare <= PWMMaxCount immediately (no slew); CompareUpdated pulses; AtTarget re-evaluated.
//  - Enable deasserted in any state:
//    - At the next PeriodSync: Compare <= 0, state IDLE, target discarded, CompareUpdated pulses if Compare was nonzero.
//    - Until that PeriodSync, the FSM freezes (no ramp step) and TargetReady=0.
//  - Enable reasserted before that PeriodSync: the freeze is cancelled and the previous state resumes.
//  - Target == 0 while in IDLE with Enable=1: go to SETTLED directly.
//  - Rst mid-ramp: immediate return to reset values; no partial step is retained.
//  - Arithmetic: no wrap is possible. Compare stays in [0, PWMMaxCount] at all times after the first PeriodSync following any PWMMaxCount change.
// STRUCTURE
//  Shared package pwm_pkg:
//  - typedef enum logic [1:0] {RAMP_IDLE, RAMP_SETTLED, RAMP_RAMPING} ramp_state_t.
//  - localparam BIT_WIDTH default; clamp function min_u().
//  Sub-module pwm_slew_step (combinational):
//  - Inputs: current, target, step.
//  - Output: next value with step-limit and RampStep==0 handling.
//  - Unit-tested separately.
//  Top: FSM, target register, PeriodSync-qualified update, CompareUpdated/AtTarget flops.
// TESTING
//  1 Reset: Rst=1 mid-sim -> Compare=0, TargetReady=0, AtTarget=0 immediately (async); after release TargetReady=0 while Enable=0.
//  2 Ramp up: PWMMaxCount=500, RampStep=50, accept 300 from 0 -> Compare 50,100..300 on 6 successive PeriodSync; AtTarget=1 after 6th; TargetReady=0 throughout.
//  3 Ramp down/partial step: from 300 accept 150, RampStep=40 -> 260,220,180,150 (last step 30); 4 CompareUpdated pulses.
//  4 Clamp: accept 600 with PWMMaxCount=500, RampStep=0 -> Compare=500 on next PeriodSync; then PWMMaxCount=400 -> Compare=400 on next PeriodSync.
//  5 Sync coincidence: accept and PeriodSync in same cycle -> no change that period; change on following PeriodSync.
//  6 Enable drop mid-ramp at Compare=120 -> Compare=0 and IDLE on next PeriodSync; new target accepted only after Enable=1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM compare path.
package pwm_pkg;

    // Default datapath width; matches the carrier counter in PWMGenTop.
    localparam int DEFAULT_BIT_WIDTH = 16;

    typedef enum logic [1:0] {
        RAMP_IDLE,
        RAMP_SETTLED,
        RAMP_RAMPING
    } ramp_state_t;

    // Unsigned minimum, used for clamping against the carrier peak.
    // Sized by the package width, so a wider datapath is configured here.
    function automatic logic [DEFAULT_BIT_WIDTH-1:0] min_u(
        input logic [DEFAULT_BIT_WIDTH-1:0] a,
        input logic [DEFAULT_BIT_WIDTH-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/pwm_slew_step.sv
// One slew step: moves current toward target by at most step.
// A step of zero means "no limit": the result is the target itself.
module pwm_slew_step #(
    parameter int BIT_WIDTH = 16
) (
    input  logic [BIT_WIDTH-1:0] current,
    input  logic [BIT_WIDTH-1:0] target,
    input  logic [BIT_WIDTH-1:0] step,
    output logic [BIT_WIDTH-1:0] next_value
);

    // One extra bit keeps the signed difference exact for any pair of inputs.
    logic signed [BIT_WIDTH:0] diff;
    logic        [BIT_WIDTH:0] mag;
    logic                      reach;

    assign diff  = $signed({1'b0, target}) - $signed({1'b0, current});
    assign mag   = diff[BIT_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign reach = (step == '0) || (mag <= {1'b0, step});

    // Land exactly on the target when it is within one step; otherwise move
    // a full step in the direction of the difference (cannot overshoot/wrap).
    always_comb begin
        next_value = target;
        if (!reach) begin
            next_value = diff[BIT_WIDTH] ? (current - step) : (current + step);
        end
    end

endmodule

// File: rtl/pwm_compare_ramp.sv
// Compare-word generator: accepts a duty target, clamps it to the carrier
// peak and slews Compare toward it once per carrier period.
module pwm_compare_ramp
    import pwm_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic                 MClk,
    input  logic                 Rst,
    input  logic                 Enable,
    input  logic                 PeriodSync,
    input  logic [BIT_WIDTH-1:0] PWMMaxCount,
    input  logic [BIT_WIDTH-1:0] RampStep,
    input  logic [BIT_WIDTH-1:0] TargetCompare,
    input  logic                 TargetValid,
    output logic                 TargetReady,
    output logic [BIT_WIDTH-1:0] Compare,
    output logic                 CompareUpdated,
    output logic                 AtTarget
);

    ramp_state_t          state_reg, state_next;
    logic [BIT_WIDTH-1:0] compare_reg, compare_next;
    logic [BIT_WIDTH-1:0] target_reg, target_next;
    logic                 updated_reg;
    logic                 at_target_reg;

    logic [BIT_WIDTH-1:0] cur_clamped;
    logic [BIT_WIDTH-1:0] tgt_clamped;
    logic [BIT_WIDTH-1:0] accept_value;
    logic [BIT_WIDTH-1:0] slew_value;
    logic                 accept;

    // Ready whenever not mid-ramp and enabled; an Enable drop freezes intake
    // until the next period start. Held low while reset is asserted.
    assign TargetReady = ~Rst & Enable & (state_reg != RAMP_RAMPING);
    assign accept      = TargetValid & TargetReady;

    // A lowered carrier peak pulls both Compare and target down without slew.
    assign cur_clamped  = min_u(compare_reg, PWMMaxCount);
    assign tgt_clamped  = min_u(target_reg, PWMMaxCount);
    assign accept_value = min_u(TargetCompare, PWMMaxCount);

    pwm_slew_step #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_slew (
        .current    (cur_clamped),
        .target     (tgt_clamped),
        .step       (RampStep),
        .next_value (slew_value)
    );

    // Next-state logic: Compare only moves at a period start; an accept
    // never moves Compare itself, only the target and state.
    always_comb begin
        state_next   = state_reg;
        compare_next = compare_reg;
        target_next  = target_reg;

        if (PeriodSync) begin
            if (!Enable) begin
                compare_next = '0;
                target_next  = '0;
                state_next   = RAMP_IDLE;
            end else begin
                target_next = tgt_clamped;
                if (state_reg == RAMP_RAMPING) begin
                    compare_next = slew_value;
                    if (slew_value == tgt_clamped) begin
                        state_next = RAMP_SETTLED;
                    end
                end else begin
                    compare_next = cur_clamped;
                end
            end
        end

        // Accept is only possible in IDLE/SETTLED with Enable high, so it
        // never collides with the ramp or disable paths above.
        if (accept) begin
            target_next = accept_value;
            state_next  = (accept_value == compare_next) ? RAMP_SETTLED : RAMP_RAMPING;
        end
    end

    // State, Compare, target and the two status flops.
    always_ff @(posedge MClk or posedge Rst) begin
        if (Rst) begin
            state_reg     <= RAMP_IDLE;
            compare_reg   <= '0;
            target_reg    <= '0;
            updated_reg   <= 1'b0;
            at_target_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            compare_reg   <= compare_next;
            target_reg    <= target_next;
            updated_reg   <= (compare_next != compare_reg);
            at_target_reg <= (state_next == RAMP_SETTLED) && (compare_next == target_next);
        end
    end

    assign Compare        = compare_reg;
    assign CompareUpdated = updated_reg;
    assign AtTarget       = at_target_reg;

endmodule
